// File: rtl/mpu_seq.sv
// mpu_seq: instruction sequencer placed directly in front of mpu_alu.
// It fetches 32-bit instruction words over a strobe/ack bus and decodes them.
// Operands come from a local 8x64 register file and are presented to the ALU
// as registered values. After the ALU settles, the result is written back and
// the flags are latched. Execution continues until a HALT instruction.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   start, start_pc      begin execution (accepted only in IDLE or DONE)
//   busy, done, pc       status and program counter
//   i_adr/i_stb/i_dat/i_ack  instruction fetch bus
//   h_we/h_adr/h_dat     host register write (dropped while busy)
//   h_rdat               registered host read of reg[h_adr]
//   alu_*                registered operands/control to the ALU
//   alu_res, alu_flags   combinational ALU results
//   flags                flags of the last executed ALU instruction
module mpu_seq #(
    parameter int PC_W = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] i_adr,
    output logic            i_stb,
    input  logic [31:0]     i_dat,
    input  logic            i_ack,
    input  logic            h_we,
    input  logic [2:0]      h_adr,
    input  logic [63:0]     h_dat,
    output logic [63:0]     h_rdat,
    output logic [3:0]      alu_op,
    output logic [1:0]      alu_size,
    output logic [63:0]     alu_o0,
    output logic [63:0]     alu_o1,
    output logic [63:0]     alu_o2,
    output logic [2:0]      alu_s0,
    output logic [2:0]      alu_s1,
    output logic [2:0]      alu_s2,
    output logic [2:0]      alu_sres,
    input  logic [63:0]     alu_res,
    input  logic [7:0]      alu_flags,
    output logic [7:0]      flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [63:0] regs [0:7];
    logic [63:0] res_q;
    logic [7:0]  flg_q;

    logic [3:0]  ir_op;
    logic [1:0]  ir_size;
    logic [2:0]  ir_rd, ir_ra, ir_rb, ir_rc;
    logic [2:0]  ir_s0, ir_s1, ir_s2, ir_sres;
    logic        unused_rsvd;

    assign ir_op    = ir[31:28];
    assign ir_size  = ir[27:26];
    assign ir_rd    = ir[25:23];
    assign ir_ra    = ir[22:20];
    assign ir_rb    = ir[19:17];
    assign ir_rc    = ir[16:14];
    assign ir_s0    = ir[13:11];
    assign ir_s1    = ir[10:8];
    assign ir_s2    = ir[7:5];
    assign ir_sres  = ir[4:2];
    // Bits [1:0] are reserved and have no effect on execution.
    assign unused_rsvd = ^ir[1:0];

    // The fetch address always tracks the program counter.
    assign i_adr = pc;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            i_stb    <= 1'b0;
            pc       <= '0;
            flags    <= '0;
            h_rdat   <= '0;
            ir       <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            alu_op   <= '0;
            alu_size <= '0;
            alu_o0   <= '0;
            alu_o1   <= '0;
            alu_o2   <= '0;
            alu_s0   <= '0;
            alu_s1   <= '0;
            alu_s2   <= '0;
            alu_sres <= '0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            h_rdat <= regs[h_adr];
            case (state)
                S_IDLE, S_DONE: begin
                    // A host write and a start in the same cycle both take effect.
                    if (h_we) regs[h_adr] <= h_dat;
                    if (start) begin
                        pc    <= start_pc;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        i_stb <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_ack) begin
                        ir    <= i_dat;
                        i_stb <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (ir_op)
                        4'h0: begin
                            pc    <= pc + 1'b1;
                            i_stb <= 1'b1;
                            state <= S_FETCH;
                        end
                        4'hF: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                        default: begin
                            alu_op   <= ir_op;
                            alu_size <= ir_size;
                            alu_o0   <= regs[ir_ra];
                            alu_o1   <= regs[ir_rb];
                            alu_o2   <= regs[ir_rc];
                            alu_s0   <= ir_s0;
                            alu_s1   <= ir_s1;
                            alu_s2   <= ir_s2;
                            alu_sres <= ir_sres;
                            state    <= S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    flg_q <= alu_flags;
                    state <= S_WB;
                end
                S_WB: begin
                    regs[ir_rd] <= res_q;
                    flags       <= flg_q;
                    pc          <= pc + 1'b1;
                    i_stb       <= 1'b1;
                    state       <= S_FETCH;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    i_stb <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_seq.sv
// tb_mpu_seq: directed bench for mpu_seq with an instruction-level model.
// The negedge monitor answers the fetch bus and runs the model.
// It compares status, pc, flags, host reads and ALU operands every cycle.
// Stimulus adds hand-computed literal checks.
module tb_mpu_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        busy, done, i_stb;
    logic [7:0]  pc, i_adr;
    logic [31:0] i_dat = '0;
    logic        i_ack;
    logic        bus_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic        h_we = 1'b0;
    logic [2:0]  h_adr = '0;
    logic [63:0] h_dat = '0;
    logic [63:0] h_rdat;
    logic [3:0]  alu_op;
    logic [1:0]  alu_size;
    logic [63:0] alu_o0, alu_o1, alu_o2;
    logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
    logic [63:0] alu_res;
    logic [7:0]  alu_flags, flags;

    int errors = 0;
    int checks = 0;

    // bench controls
    logic [31:0] imem [256];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        stub_fixed = 1'b1;

    // model state
    logic [63:0] mregs [8];
    logic [7:0]  mflags = '0;
    logic [7:0]  mpc = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] exp_rdat = '0;
    logic [31:0] cur_ir = '0;
    int          ph = -1;
    int          wait_cnt = 0;
    logic [3:0]  e_op;
    logic [1:0]  e_sz;
    logic [63:0] e_o0, e_o1, e_o2, e_res;
    logic [2:0]  e_s0, e_s1, e_s2, e_sres, e_rd;
    logic [7:0]  e_flg;

    always #5 sys_clk = ~sys_clk;
    assign i_ack = bus_ack | force_ack;

    mpu_seq #(.PC_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .start_pc(start_pc),
        .busy(busy), .done(done), .pc(pc), .i_adr(i_adr), .i_stb(i_stb),
        .i_dat(i_dat), .i_ack(i_ack), .h_we(h_we), .h_adr(h_adr), .h_dat(h_dat),
        .h_rdat(h_rdat), .alu_op(alu_op), .alu_size(alu_size),
        .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_sres(alu_sres),
        .alu_res(alu_res), .alu_flags(alu_flags), .flags(flags)
    );

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] sz,
                                        input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] rc,
                                        input logic [2:0] s0, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic [2:0] sres);
        return {op, sz, rd, ra, rb, rc, s0, s1, s2, sres, 2'b00};
    endfunction

    function automatic logic [63:0] stub_res(input logic fixed, input logic [3:0] op,
                                             input logic [63:0] o0, input logic [63:0] o1,
                                             input logic [63:0] o2);
        return fixed ? 64'h1234 : (o0 + (o1 ^ o2) + {60'd0, op});
    endfunction

    function automatic logic [7:0] stub_flg(input logic fixed, input logic [3:0] op,
                                            input logic [1:0] sz, input logic [2:0] sres);
        return fixed ? 8'h01 : {op, sz, sres[1:0]};
    endfunction

    // ALU stub
    always_comb begin
        alu_res   = stub_res(stub_fixed, alu_op, alu_o0, alu_o1, alu_o2);
        alu_flags = stub_flg(stub_fixed, alu_op, alu_size, alu_sres);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: bus responder, instruction-level model and per-cycle compare
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                for (int i = 0; i < 8; i++) mregs[i] = '0;
                mflags = '0; mpc = '0; m_busy = 1'b0; m_done = 1'b0;
                exp_rdat = '0; ph = -1; wait_cnt = 0; bus_ack = 1'b0;
            end else begin
                if (ph >= 0) ph++;
                chk("busy", 64'(busy), 64'(m_busy));
                chk("done", 64'(done), 64'(m_done));
                chk("i_stb", 64'(i_stb), 64'(m_busy && ph < 0));
                chk("pc", 64'(pc), 64'(mpc));
                chk("i_adr", 64'(i_adr), 64'(mpc));
                chk("flags", 64'(flags), 64'(mflags));
                chk("h_rdat", h_rdat, exp_rdat);
                if (ph == 2) begin
                    chk("alu_op", 64'(alu_op), 64'(e_op));
                    chk("alu_size", 64'(alu_size), 64'(e_sz));
                    chk("alu_o0", alu_o0, e_o0);
                    chk("alu_o1", alu_o1, e_o1);
                    chk("alu_o2", alu_o2, e_o2);
                    chk("alu_s0", 64'(alu_s0), 64'(e_s0));
                    chk("alu_s1", 64'(alu_s1), 64'(e_s1));
                    chk("alu_s2", 64'(alu_s2), 64'(e_s2));
                    chk("alu_sres", 64'(alu_sres), 64'(e_sres));
                end
                exp_rdat = mregs[h_adr];
                // model effects of the coming rising edge
                if (!m_busy) begin
                    if (h_we) mregs[h_adr] = h_dat;
                    if (start) begin
                        m_busy = 1'b1; m_done = 1'b0; mpc = start_pc;
                    end
                end else if (ph == 1) begin
                    case (cur_ir[31:28])
                        4'h0: begin mpc = mpc + 8'd1; ph = -1; end
                        4'hF: begin m_busy = 1'b0; m_done = 1'b1; ph = -1; end
                        default: begin
                            e_op = cur_ir[31:28]; e_sz = cur_ir[27:26];
                            e_rd = cur_ir[25:23];
                            e_o0 = mregs[cur_ir[22:20]];
                            e_o1 = mregs[cur_ir[19:17]];
                            e_o2 = mregs[cur_ir[16:14]];
                            e_s0 = cur_ir[13:11]; e_s1 = cur_ir[10:8];
                            e_s2 = cur_ir[7:5];   e_sres = cur_ir[4:2];
                            e_res = stub_res(stub_fixed, e_op, e_o0, e_o1, e_o2);
                            e_flg = stub_flg(stub_fixed, e_op, e_sz, e_sres);
                        end
                    endcase
                end else if (ph == 3) begin
                    mregs[e_rd] = e_res; mflags = e_flg; mpc = mpc + 8'd1; ph = -1;
                end
                // fetch responder
                if (i_stb && ack_en) begin
                    if (wait_cnt == ack_delay) begin
                        bus_ack = 1'b1; i_dat = imem[i_adr]; cur_ir = imem[i_adr];
                        ph = 0; wait_cnt = 0;
                    end else begin
                        bus_ack = 1'b0; wait_cnt++;
                    end
                end else begin
                    bus_ack = 1'b0; wait_cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [63:0] d);
        h_we = 1'b1; h_adr = a; h_dat = d;
        tick();
        h_we = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [63:0] d);
        h_adr = a;
        tick();
        d = h_rdat;
    endtask

    // Returns cycles from the start-sampling edge until done is seen.
    task automatic run(input logic [7:0] spc, input bit inject, output int cyc);
        start_pc = spc; start = 1'b1;
        tick();
        start = 1'b0; h_we = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            if (inject && cyc == 3) begin
                h_we = 1'b1; h_adr = 3'd2; h_dat = 64'hDEAD;
                start = 1'b1; start_pc = 8'h40;
            end
            tick();
            cyc++;
            h_we = 1'b0; start = 1'b0;
        end
        if (done !== 1'b1) chk("run_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        int          cyc;
        logic [63:0] rd;
        for (int i = 0; i < 256; i++) imem[i] = '0;

        // power-on reset
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_pc", 64'(pc), 64'd0);

        // single ALU op then HALT, zero-wait
        host_write(3'd1, 64'h55);
        host_write(3'd2, 64'hAA00);
        host_write(3'd3, 64'h550000);
        imem[8'h10] = enc(4'h1, 2'd0, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3);
        imem[8'h11] = 32'hF000_0000;
        stub_fixed = 1'b1; ack_delay = 0;
        run(8'h10, 1'b0, cyc);
        chk("t1_cycles", 64'(cyc), 64'd7);
        chk("t1_pc", 64'(pc), 64'h11);
        chk("t1_flags", 64'(flags), 64'h01);
        chk("t1_hold_op", 64'(alu_op), 64'd1);
        chk("t1_hold_o0", alu_o0, 64'h55);
        chk("t1_hold_o1", alu_o1, 64'hAA00);
        chk("t1_hold_o2", alu_o2, 64'h550000);
        chk("t1_hold_s1", 64'(alu_s1), 64'd1);
        chk("t1_hold_s2", 64'(alu_s2), 64'd2);
        chk("t1_hold_sres", 64'(alu_sres), 64'd3);
        read_reg(3'd4, rd);
        chk("t1_reg4", rd, 64'h1234);

        // same program with 3-cycle fetch wait, plus host write/start while busy
        ack_delay = 3;
        h_adr = 3'd2;
        run(8'h10, 1'b1, cyc);
        chk("t2_cycles", 64'(cyc), 64'd13);
        chk("t2_flags", 64'(flags), 64'h01);
        chk("t2_pc", 64'(pc), 64'h11);
        read_reg(3'd2, rd);
        chk("t2_reg2_kept", rd, 64'hAA00);
        read_reg(3'd4, rd);
        chk("t2_reg4", rd, 64'h1234);

        // chained dependency
        ack_delay = 0; stub_fixed = 1'b0;
        imem[8'h20] = enc(4'h2, 2'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
        imem[8'h21] = enc(4'h3, 2'd1, 3'd6, 3'd5, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2);
        imem[8'h22] = 32'hF000_0000;
        run(8'h20, 1'b0, cyc);
        chk("t3_cycles", 64'(cyc), 64'd11);
        chk("t3_o0_fwd", alu_o0, 64'h55AA57);
        chk("t3_flags", 64'(flags), 64'h36);
        read_reg(3'd5, rd);
        chk("t3_reg5", rd, 64'h55AA57);
        read_reg(3'd6, rd);
        chk("t3_reg6", rd, 64'h55AAAF);

        // NOP at 0xFF wraps to HALT at 0x00
        imem[8'hFF] = 32'h0000_0000;
        imem[8'h00] = 32'hF000_0000;
        run(8'hFF, 1'b0, cyc);
        chk("t4_cycles", 64'(cyc), 64'd5);
        chk("t4_pc", 64'(pc), 64'h00);
        chk("t4_flags", 64'(flags), 64'h36);
        read_reg(3'd6, rd);
        chk("t4_reg6", rd, 64'h55AAAF);

        // host write and start together while DONE
        h_we = 1'b1; h_adr = 3'd2; h_dat = 64'hDEAD;
        run(8'h00, 1'b0, cyc);
        chk("t5_cycles", 64'(cyc), 64'd3);
        read_reg(3'd2, rd);
        chk("t5_reg2", rd, 64'hDEAD);

        // reset in the middle of a stalled fetch
        host_write(3'd7, 64'h77);
        ack_en = 1'b0;
        start_pc = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_stb_pre", 64'(i_stb), 64'd1);
        chk("t6_pc_pre", 64'(pc), 64'h05);
        sys_rst = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_stb", 64'(i_stb), 64'd0);
        chk("t6_pc", 64'(pc), 64'd0);
        chk("t6_iadr", 64'(i_adr), 64'd0);
        chk("t6_flags", 64'(flags), 64'd0);
        chk("t6_hrdat", h_rdat, 64'd0);
        chk("t6_alu_op", 64'(alu_op), 64'd0);
        chk("t6_alu_o0", alu_o0, 64'd0);
        chk("t6_alu_o1", alu_o1, 64'd0);
        chk("t6_alu_sres", 64'(alu_sres), 64'd0);
        tick();
        sys_rst = 1'b0;
        force_ack = 1'b1;
        tick(); tick();
        force_ack = 1'b0;
        chk("t6_ack_ign_busy", 64'(busy), 64'd0);
        chk("t6_ack_ign_stb", 64'(i_stb), 64'd0);
        chk("t6_ack_ign_pc", 64'(pc), 64'd0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rd);
            chk("t6_reg_clr", rd, 64'd0);
        end
        ack_en = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
